// File: rtl/axis_insert_header_arbiter_if.sv
// Source-side and core-side header/body handshake bundle for the insert-header arbiter.
// slave is the arbiter's view, master is the view of whatever drives the sources and the core.
interface axis_insert_header_arbiter_if #(
  parameter int DATA_WD = 32,
  parameter int NUM_SRC = 4
);
  localparam int DATA_BYTE_WD = DATA_WD / 8;
  localparam int CNT_WD       = $clog2(DATA_BYTE_WD) + 1;

  logic [NUM_SRC-1:0]              s_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [NUM_SRC*CNT_WD-1:0]       s_byte_insert_cnt;
  logic [NUM_SRC-1:0]              s_ready_insert;

  logic [NUM_SRC-1:0]              s_valid_in;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [NUM_SRC-1:0]              s_last_in;
  logic [NUM_SRC-1:0]              s_ready_in;

  logic                            c_valid_insert;
  logic [DATA_WD-1:0]              c_data_insert;
  logic [DATA_BYTE_WD-1:0]         c_keep_insert;
  logic [CNT_WD-1:0]               c_byte_insert_cnt;
  logic                            c_ready_insert;

  logic                            c_valid_in;
  logic [DATA_WD-1:0]              c_data_in;
  logic [DATA_BYTE_WD-1:0]         c_keep_in;
  logic                            c_last_in;
  logic                            c_ready_in;

  modport slave (
    input  s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    output s_ready_insert,
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_ready_in,
    output c_valid_insert, c_data_insert, c_keep_insert, c_byte_insert_cnt,
    input  c_ready_insert,
    output c_valid_in, c_data_in, c_keep_in, c_last_in,
    input  c_ready_in
  );

  modport master (
    output s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    input  s_ready_insert,
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_ready_in,
    input  c_valid_insert, c_data_insert, c_keep_insert, c_byte_insert_cnt,
    output c_ready_insert,
    input  c_valid_in, c_data_in, c_keep_in, c_last_in,
    output c_ready_in
  );
endinterface

// File: rtl/axis_insert_header_arbiter.sv
// Packet-granular round-robin arbiter sharing one insert-header core between NUM_SRC sources.
// IDLE | no owner, arbitrate on header valids  HDR | forward owner's header  BODY | forward owner's body until last
module axis_insert_header_arbiter #(
  parameter int DATA_WD = 32,
  parameter int NUM_SRC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_insert_header_arbiter_if.slave bus,
  output logic [NUM_SRC-1:0]         grant,
  output logic                       busy,
  output logic                       pkt_done
);
  localparam int DATA_BYTE_WD = DATA_WD / 8;
  localparam int CNT_WD       = $clog2(DATA_BYTE_WD) + 1;
  localparam int PTR_WD       = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [PTR_WD-1:0] rr_ptr, rr_ptr_next;
  logic [PTR_WD-1:0] g_idx, g_idx_next;
  logic [PTR_WD-1:0] win_idx, cand;
  logic              win_found;

  logic [DATA_WD-1:0]      hdr_data  [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] hdr_keep  [NUM_SRC];
  logic [CNT_WD-1:0]       hdr_cnt   [NUM_SRC];
  logic [DATA_WD-1:0]      body_data [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] body_keep [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign hdr_data[i]  = bus.s_data_insert[i*DATA_WD +: DATA_WD];
    assign hdr_keep[i]  = bus.s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign hdr_cnt[i]   = bus.s_byte_insert_cnt[i*CNT_WD +: CNT_WD];
    assign body_data[i] = bus.s_data_in[i*DATA_WD +: DATA_WD];
    assign body_keep[i] = bus.s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      g_idx  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      g_idx  <= g_idx_next;
    end
  end

  // First header requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = PTR_WD'((int'(rr_ptr) + k) % NUM_SRC);
      if (!win_found && bus.s_valid_insert[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next            = state;
    rr_ptr_next           = rr_ptr;
    g_idx_next            = g_idx;
    pkt_done              = 1'b0;
    bus.s_ready_insert    = '0;
    bus.s_ready_in        = '0;
    bus.c_valid_insert    = 1'b0;
    bus.c_data_insert     = '0;
    bus.c_keep_insert     = '0;
    bus.c_byte_insert_cnt = '0;
    bus.c_valid_in        = 1'b0;
    bus.c_data_in         = '0;
    bus.c_keep_in         = '0;
    bus.c_last_in         = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          g_idx_next = win_idx;
          state_next = HDR;
        end
      end
      HDR: begin
        bus.c_valid_insert         = bus.s_valid_insert[g_idx];
        bus.s_ready_insert[g_idx]  = bus.c_ready_insert;
        if (bus.s_valid_insert[g_idx]) begin
          bus.c_data_insert     = hdr_data[g_idx];
          bus.c_keep_insert     = hdr_keep[g_idx];
          bus.c_byte_insert_cnt = hdr_cnt[g_idx];
          if (bus.c_ready_insert) state_next = BODY;
        end
      end
      BODY: begin
        bus.c_valid_in         = bus.s_valid_in[g_idx];
        bus.s_ready_in[g_idx]  = bus.c_ready_in;
        if (bus.s_valid_in[g_idx]) begin
          bus.c_data_in = body_data[g_idx];
          bus.c_keep_in = body_keep[g_idx];
          bus.c_last_in = bus.s_last_in[g_idx];
          if (bus.c_ready_in && bus.s_last_in[g_idx]) begin
            pkt_done    = 1'b1;
            rr_ptr_next = (g_idx == PTR_WD'(NUM_SRC - 1)) ? '0 : g_idx + PTR_WD'(1);
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state != IDLE) grant[g_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// Directed bench for the insert-header arbiter: reset, single packet, round-robin order,
// header/body gating, body back-pressure and reset mid-packet.
`timescale 1ns/1ps
module tb_axis_insert_header_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] grant;
  logic          busy;
  logic          pkt_done;
  int            checks = 0;
  int            passes = 0;

  logic [NS-1:0] hv, bv, bl;
  logic [31:0]   hd [NS];
  logic [31:0]   bd [NS];
  logic [3:0]    hk [NS];
  logic [3:0]    bk [NS];
  logic [2:0]    hc [NS];

  always #5 clk = ~clk;

  axis_insert_header_arbiter_if #(.DATA_WD(DW), .NUM_SRC(NS)) bus ();

  axis_insert_header_arbiter #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant    (grant),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  assign bus.s_valid_insert = hv;
  assign bus.s_valid_in     = bv;
  assign bus.s_last_in      = bl;
  for (genvar i = 0; i < NS; i++) begin : g_pack
    assign bus.s_data_insert[i*DW +: DW]   = hd[i];
    assign bus.s_keep_insert[i*4 +: 4]     = hk[i];
    assign bus.s_byte_insert_cnt[i*3 +: 3] = hc[i];
    assign bus.s_data_in[i*DW +: DW]       = bd[i];
    assign bus.s_keep_in[i*4 +: 4]         = bk[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    hv = '0; bv = '0; bl = '0;
    for (int i = 0; i < NS; i++) begin
      hd[i] = '0; bd[i] = '0; hk[i] = '0; bk[i] = '0; hc[i] = '0;
    end
  endtask

  task automatic test_reset();
    hv = '1; bv = '1;
    bus.c_ready_insert = 1'b1; bus.c_ready_in = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else passes++;
    checks++; if (bus.s_ready_insert !== 4'b0000) $display("FAIL reset_s_ready_insert: got %b want 0000", bus.s_ready_insert); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0000) $display("FAIL reset_s_ready_in: got %b want 0000", bus.s_ready_in); else passes++;
    checks++; if (bus.c_valid_insert !== 1'b0) $display("FAIL reset_c_valid_insert: got %b want 0", bus.c_valid_insert); else passes++;
    checks++; if (bus.c_valid_in !== 1'b0) $display("FAIL reset_c_valid_in: got %b want 0", bus.c_valid_in); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (pkt_done !== 1'b0) $display("FAIL reset_pkt_done: got %b want 0", pkt_done); else passes++;
    clear_all();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_packet();
    logic [31:0] beats [3];
    beats[0] = 32'h1111_0001; beats[1] = 32'h2222_0002; beats[2] = 32'h3333_0003;
    bus.c_ready_insert = 1'b1; bus.c_ready_in = 1'b1;
    hd[2] = 32'hA5A5_0000; hk[2] = 4'b0011; hc[2] = 3'd2; hv = 4'b0100;
    #1;
    checks++; if (grant !== 4'b0000) $display("FAIL single_idle_grant: got %b want 0000", grant); else passes++;
    step();
    checks++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passes++;
    checks++; if (bus.c_valid_insert !== 1'b1) $display("FAIL single_c_valid_insert: got %b want 1", bus.c_valid_insert); else passes++;
    checks++; if (bus.c_data_insert !== 32'hA5A5_0000) $display("FAIL single_hdr_data: got %h want a5a50000", bus.c_data_insert); else passes++;
    checks++; if (bus.c_keep_insert !== 4'b0011) $display("FAIL single_hdr_keep: got %b want 0011", bus.c_keep_insert); else passes++;
    checks++; if (bus.c_byte_insert_cnt !== 3'd2) $display("FAIL single_hdr_cnt: got %0d want 2", bus.c_byte_insert_cnt); else passes++;
    checks++; if (bus.s_ready_insert !== 4'b0100) $display("FAIL single_s_ready_insert: got %b want 0100", bus.s_ready_insert); else passes++;
    bv[2] = 1'b1; bd[2] = beats[0]; bk[2] = 4'hF; bl[2] = 1'b0;
    #1;
    checks++; if (bus.c_valid_in !== 1'b0) $display("FAIL single_hdr_c_valid_in: got %b want 0", bus.c_valid_in); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0000) $display("FAIL single_hdr_s_ready_in: got %b want 0000", bus.s_ready_in); else passes++;
    step();
    hv = '0;
    #1;
    checks++; if (bus.c_valid_insert !== 1'b0) $display("FAIL single_body_c_valid_insert: got %b want 0", bus.c_valid_insert); else passes++;
    checks++; if (bus.c_data_insert !== 32'h0) $display("FAIL single_body_c_data_insert: got %h want 0", bus.c_data_insert); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0100) $display("FAIL single_body_s_ready_in: got %b want 0100", bus.s_ready_in); else passes++;
    for (int b = 0; b < 3; b++) begin
      bd[2] = beats[b]; bl[2] = (b == 2);
      #1;
      checks++; if (bus.c_valid_in !== 1'b1) $display("FAIL single_beat%0d_valid: got %b want 1", b, bus.c_valid_in); else passes++;
      checks++; if (bus.c_data_in !== beats[b]) $display("FAIL single_beat%0d_data: got %h want %h", b, bus.c_data_in, beats[b]); else passes++;
      checks++; if (bus.c_last_in !== (b == 2)) $display("FAIL single_beat%0d_last: got %b want %b", b, bus.c_last_in, (b == 2)); else passes++;
      checks++; if (pkt_done !== (b == 2)) $display("FAIL single_beat%0d_pkt_done: got %b want %b", b, pkt_done, (b == 2)); else passes++;
      step();
    end
    bv = '0; bl = '0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b want 0", busy); else passes++;
    checks++; if (grant !== 4'b0000) $display("FAIL single_end_grant: got %b want 0000", grant); else passes++;
    checks++; if (pkt_done !== 1'b0) $display("FAIL single_end_pkt_done: got %b want 0", pkt_done); else passes++;
    clear_all();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.c_ready_insert = 1'b1; bus.c_ready_in = 1'b1;
    for (int i = 0; i < NS; i++) begin
      hd[i] = 32'hC000_0000 + i; hk[i] = 4'hF; hc[i] = 3'd4;
      bd[i] = 32'hB000_0000 + i; bk[i] = 4'hF;
    end
    hv = '1; bv = '1; bl = '1;
    for (int p = 0; p < 5; p++) begin
      exp_g = 4'b0001 << (p % NS);
      step();
      checks++; if (grant !== exp_g) $display("FAIL rr_pkt%0d_hdr_grant: got %b want %b", p, grant, exp_g); else passes++;
      step();
      checks++; if (grant !== exp_g) $display("FAIL rr_pkt%0d_body_grant: got %b want %b", p, grant, exp_g); else passes++;
      checks++; if (bus.c_data_in !== 32'hB000_0000 + (p % NS)) $display("FAIL rr_pkt%0d_data: got %h want %h", p, bus.c_data_in, 32'hB000_0000 + (p % NS)); else passes++;
      checks++; if (pkt_done !== 1'b1) $display("FAIL rr_pkt%0d_pkt_done: got %b want 1", p, pkt_done); else passes++;
      step();
      checks++; if (grant !== 4'b0000) $display("FAIL rr_pkt%0d_idle_grant: got %b want 0000", p, grant); else passes++;
    end
    clear_all();
  endtask

  task automatic test_body_in_hdr();
    bus.c_ready_insert = 1'b0; bus.c_ready_in = 1'b1;
    hd[1] = 32'h1234_5678; hk[1] = 4'hF; hc[1] = 3'd4; hv = 4'b0010;
    bd[1] = 32'hCAFE_0001; bk[1] = 4'hF; bl[1] = 1'b1; bv = 4'b0010;
    step();
    checks++; if (grant !== 4'b0010) $display("FAIL hdr_grant: got %b want 0010", grant); else passes++;
    checks++; if (bus.c_valid_insert !== 1'b1) $display("FAIL hdr_c_valid_insert: got %b want 1", bus.c_valid_insert); else passes++;
    checks++; if (bus.s_ready_insert !== 4'b0000) $display("FAIL hdr_s_ready_insert_low: got %b want 0000", bus.s_ready_insert); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0000) $display("FAIL hdr_s_ready_in: got %b want 0000", bus.s_ready_in); else passes++;
    checks++; if (bus.c_valid_in !== 1'b0) $display("FAIL hdr_c_valid_in: got %b want 0", bus.c_valid_in); else passes++;
    hv = '0;
    #1;
    checks++; if (bus.c_valid_insert !== 1'b0) $display("FAIL hdr_drop_c_valid_insert: got %b want 0", bus.c_valid_insert); else passes++;
    checks++; if (bus.c_data_insert !== 32'h0) $display("FAIL hdr_drop_c_data_insert: got %h want 0", bus.c_data_insert); else passes++;
    step();
    checks++; if (grant !== 4'b0010) $display("FAIL hdr_drop_grant_held: got %b want 0010", grant); else passes++;
    checks++; if (bus.c_valid_in !== 1'b0) $display("FAIL hdr_drop_c_valid_in: got %b want 0", bus.c_valid_in); else passes++;
    hv = 4'b0010; bus.c_ready_insert = 1'b1;
    #1;
    checks++; if (bus.s_ready_insert !== 4'b0010) $display("FAIL hdr_s_ready_insert: got %b want 0010", bus.s_ready_insert); else passes++;
    step();
    hv = '0;
    #1;
    checks++; if (bus.c_valid_in !== 1'b1) $display("FAIL hdr_body_c_valid_in: got %b want 1", bus.c_valid_in); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0010) $display("FAIL hdr_body_s_ready_in: got %b want 0010", bus.s_ready_in); else passes++;
    checks++; if (bus.c_data_in !== 32'hCAFE_0001) $display("FAIL hdr_body_data: got %h want cafe0001", bus.c_data_in); else passes++;
    step();
    bv = '0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL hdr_end_busy: got %b want 0", busy); else passes++;
    clear_all();
  endtask

  task automatic test_backpressure();
    int   b;
    logic rdy;
    bus.c_ready_insert = 1'b1; bus.c_ready_in = 1'b1;
    hd[2] = 32'h2200_0000; hk[2] = 4'hF; hc[2] = 3'd4;
    hd[3] = 32'h3300_0000; hk[3] = 4'hF; hc[3] = 3'd4;
    hv = 4'b1100;
    step();
    checks++; if (grant !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", grant); else passes++;
    checks++; if (bus.s_ready_insert !== 4'b0100) $display("FAIL bp_s_ready_insert: got %b want 0100", bus.s_ready_insert); else passes++;
    bv[2] = 1'b1; bd[2] = 32'hD000_0000; bk[2] = 4'hF; bl[2] = 1'b0;
    step();
    hv[2] = 1'b0;
    b = 0;
    for (int n = 0; n < 16 && b < 4; n++) begin
      rdy = (n % 2 == 0);
      bus.c_ready_in = rdy;
      bd[2] = 32'hD000_0000 + b; bl[2] = (b == 3);
      #1;
      checks++; if (grant !== 4'b0100) $display("FAIL bp_cyc%0d_grant: got %b want 0100", n, grant); else passes++;
      checks++; if (bus.s_ready_insert !== 4'b0000) $display("FAIL bp_cyc%0d_src3_waits: got %b want 0000", n, bus.s_ready_insert); else passes++;
      checks++; if (bus.c_data_in !== 32'hD000_0000 + b) $display("FAIL bp_cyc%0d_data: got %h want %h", n, bus.c_data_in, 32'hD000_0000 + b); else passes++;
      checks++; if (bus.s_ready_in !== (rdy ? 4'b0100 : 4'b0000)) $display("FAIL bp_cyc%0d_s_ready_in: got %b want %b", n, bus.s_ready_in, (rdy ? 4'b0100 : 4'b0000)); else passes++;
      checks++; if (pkt_done !== (rdy && b == 3)) $display("FAIL bp_cyc%0d_pkt_done: got %b want %b", n, pkt_done, (rdy && b == 3)); else passes++;
      step();
      if (rdy) b++;
    end
    checks++; if (b !== 4) $display("FAIL bp_beats: got %0d want 4", b); else passes++;
    bv = '0; bl = '0; bus.c_ready_in = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL bp_end_busy: got %b want 0", busy); else passes++;
    step();
    checks++; if (grant !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", grant); else passes++;
    step();
    hv = '0;
    bv[3] = 1'b1; bd[3] = 32'h3333_3333; bk[3] = 4'hF; bl[3] = 1'b1;
    step();
    clear_all();
  endtask

  task automatic test_reset_mid_body();
    bus.c_ready_insert = 1'b1; bus.c_ready_in = 1'b0;
    hd[1] = 32'h1100_0000; hk[1] = 4'hF; hc[1] = 3'd4; hv = 4'b0010;
    step();
    checks++; if (grant !== 4'b0010) $display("FAIL rst_body_hdr_grant: got %b want 0010", grant); else passes++;
    step();
    hv = '0;
    bv[1] = 1'b1; bd[1] = 32'hE000_0001; bk[1] = 4'hF; bl[1] = 1'b0;
    #1;
    checks++; if (bus.c_valid_in !== 1'b1) $display("FAIL rst_body_c_valid_in: got %b want 1", bus.c_valid_in); else passes++;
    checks++; if (bus.s_ready_in !== 4'b0000) $display("FAIL rst_body_s_ready_in: got %b want 0000", bus.s_ready_in); else passes++;
    step();
    checks++; if (grant !== 4'b0010) $display("FAIL rst_body_hold_grant: got %b want 0010", grant); else passes++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL rst_body_busy: got %b want 0", busy); else passes++;
    checks++; if (grant !== 4'b0000) $display("FAIL rst_body_grant: got %b want 0000", grant); else passes++;
    checks++; if (bus.c_valid_in !== 1'b0) $display("FAIL rst_body_c_valid_in_after: got %b want 0", bus.c_valid_in); else passes++;
    hd[3] = 32'h3300_0000; hk[3] = 4'hF; hc[3] = 3'd4;
    hv = 4'b1010;
    step();
    checks++; if (grant !== 4'b0010) $display("FAIL rst_body_regrant: got %b want 0010", grant); else passes++;
    clear_all();
  endtask

  initial begin
    clear_all();
    rst = 1'b1;
    bus.c_ready_insert = 1'b0;
    bus.c_ready_in     = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_body_in_hdr();
    test_backpressure();
    test_reset_mid_body();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
